bcd_serial_adder: RTL and testbench

//   Parametrised multi-digit BCD adder/subtractor, digit-serial: one BCD digit per clock, LSD first.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_serial_adder_if.sv | 22 ++
 rtl/bcd_digit_adder.sv | 26 ++
 rtl/bcd_serial_adder.sv | 112 +++++++++++
 tb/tb_bcd_serial_adder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helpers for the digit-serial BCD adder.
package bcd_pkg;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nines complement of a BCD digit. Inputs above 9 wrap, but such operands
  // are flagged as errors and their result is discarded.
  function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
    return 4'd9 - d;
  endfunction
endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/response bundle between a client and the digit-serial BCD adder.
interface bcd_serial_adder_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic                      start;
  logic                      sub;
  logic                      cin;
  logic [DIGIT_W*DIGITS-1:0] a;
  logic [DIGIT_W*DIGITS-1:0] b;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] sum;
  logic                      cout;
  logic                      err;

  modport master (output start, sub, cin, a, b,
                  input  busy, done, sum, cout, err);
  modport slave  (input  start, sub, cin, a, b,
                  output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_digit_adder.sv
// One-digit BCD add with carry: s = (a+b+ci) mod 10, co = (a+b+ci) > 9.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_ci,
  output logic [DIGIT_W-1:0] o_s,
  output logic               o_co
);
  logic [DIGIT_W:0] w_t;
  logic [DIGIT_W:0] w_tm;

  // Binary sum then decimal correction when the digit overflows 9.
  always_comb begin
    w_t  = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_ci};
    w_tm = w_t - 5'd10;
    if (w_t > 5'd9) begin
      o_s  = w_tm[DIGIT_W-1:0];
      o_co = 1'b1;
    end else begin
      o_s  = w_t[DIGIT_W-1:0];
      o_co = 1'b0;
    end
  end
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first, with
// start/busy/done handshake and invalid-digit detection.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic clk,
  input  logic rst_n,
  bcd_serial_adder_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                          r_state;
  logic [IDX_W-1:0]                r_idx;
  logic [DIGITS-1:0][DIGIT_W-1:0]  r_a, r_b, r_work, r_sum;
  logic                            r_sub, r_carry, r_errw;
  logic                            r_cout, r_err, r_busy, r_done;

  logic [DIGITS-1:0][DIGIT_W-1:0]  w_in_a, w_in_b, w_work_nx;
  logic [DIGIT_W-1:0]              w_bb, w_ds;
  logic                            w_dc, w_bad, w_last;

  assign w_in_a = bus.a;
  assign w_in_b = bus.b;

  // Any non-decimal digit in either operand at the moment of acceptance.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (w_in_a[i] > 4'd9 || w_in_b[i] > 4'd9) w_bad = 1'b1;
  end

  // Subtract is done as a + nines(b) + ~borrow; the final carry inverts to borrow.
  assign w_bb   = r_sub ? nines(r_b[r_idx]) : r_b[r_idx];
  assign w_last = (r_idx == IDX_W'(DIGITS - 1));

  bcd_digit_adder u_dig (
    .i_a  (r_a[r_idx]),
    .i_b  (w_bb),
    .i_ci (r_carry),
    .o_s  (w_ds),
    .o_co (w_dc)
  );

  // Working value with the current digit merged, so the commit includes the MSD.
  always_comb begin
    w_work_nx        = r_work;
    w_work_nx[r_idx] = w_ds;
  end

  // Control FSM plus operand, working and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_errw  <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= w_in_a;
            r_b     <= w_in_b;
            r_sub   <= bus.sub;
            r_carry <= bus.sub ? ~bus.cin : bus.cin;
            r_errw  <= w_bad;
            r_idx   <= '0;
            r_work  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_work  <= w_work_nx;
          r_carry <= w_dc;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= r_errw ? '0 : w_work_nx;
            r_cout  <= r_errw ? 1'b0 : (r_sub ? ~w_dc : w_dc);
            r_err   <= r_errw;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.err  = r_err;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: directed spec cases, randomized ops against a
// decimal-arithmetic reference, handshake timing, reset abort and DIGITS=1.
module tb_bcd_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(4)) if4 ();
  bcd_serial_adder_if #(.DIGITS(1)) if1 ();

  bcd_serial_adder #(.DIGITS(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(if4));
  bcd_serial_adder #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] to_bcd(input int n, input int d);
    logic [15:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  // Plain decimal reference: add wraps mod 10^D, negative difference -> ten's complement.
  function automatic void model(input int av, input int bv, input bit s, input bit c,
                                input int d, output int sv, output bit co);
    int m;
    int r;
    m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    if (!s) begin
      r = av + bv + int'(c);
      co = (r >= m);
      sv = r % m;
    end else begin
      r = av - bv - int'(c);
      co = (r < 0);
      sv = (r < 0) ? r + m : r;
    end
  endfunction

  // Issue one op on the 4-digit DUT and wait for done (bounded); leaves FSM back in IDLE.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input bit s, input bit c,
                      output logic [15:0] sm, output bit co, output bit er,
                      output int lat, output int busyc);
    @(negedge clk);
    if4.a = a; if4.b = b; if4.sub = s; if4.cin = c; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    lat = 0; busyc = 0;
    while (if4.done !== 1'b1 && lat < 20) begin
      if (if4.busy === 1'b1) busyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) lat = 99;
    sm = if4.sum; co = if4.cout; er = if4.err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    if4.start = 0; if4.sub = 0; if4.cin = 0; if4.a = '0; if4.b = '0;
    if1.start = 0; if1.sub = 0; if1.cin = 0; if1.a = '0; if1.b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if4.busy); end
    checks++; if (if4.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", if4.done); end
    checks++; if (if4.sum !== 16'h0) begin errors++; $display("FAIL reset_sum got %h want 0000", if4.sum); end
    checks++; if (if4.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", if4.cout); end
    checks++; if (if4.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", if4.err); end
    checks++; if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.sum !== 4'h0)
      begin errors++; $display("FAIL reset_d1 got busy %b done %b sum %h want 0 0 0", if1.busy, if1.done, if1.sum); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ta[6] = '{16'h0999, 16'h9999, 16'h0005, 16'h0500, 16'h0123, 16'h0000};
    logic [15:0] tb[6] = '{16'h0001, 16'h0001, 16'h0004, 16'h0123, 16'h0500, 16'h0000};
    bit          ts[6] = '{0, 0, 0, 1, 1, 1};
    bit          tc[6] = '{0, 0, 1, 0, 0, 1};
    logic [15:0] es[6] = '{16'h1000, 16'h0000, 16'h0010, 16'h0377, 16'h9623, 16'h9999};
    bit          ec[6] = '{0, 1, 0, 0, 1, 1};
    logic [15:0] sm; bit co, er; int lat, bc;
    for (int i = 0; i < 6; i++) begin
      run4(ta[i], tb[i], ts[i], tc[i], sm, co, er, lat, bc);
      checks++; if (sm !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, sm, es[i]); end
      checks++; if (co !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %b want %b", i, co, ec[i]); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL dir%0d_err got %b want 0", i, er); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
      checks++; if (bc !== 4) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want 4", i, bc); end
    end
  endtask

  task automatic test_random();
    int av, bv, sv; bit s, c, eco;
    logic [15:0] sm, es; bit co, er; int lat, bc;
    for (int i = 0; i < 40; i++) begin
      av = int'($urandom_range(0, 9999));
      bv = int'($urandom_range(0, 9999));
      s = 1'($urandom); c = 1'($urandom);
      model(av, bv, s, c, 4, sv, eco);
      es = to_bcd(sv, 4);
      run4(to_bcd(av, 4), to_bcd(bv, 4), s, c, sm, co, er, lat, bc);
      checks++; if (sm !== es || co !== eco || er !== 1'b0 || lat !== 4)
        begin errors++; $display("FAIL rand%0d %0d %s %0d cin%0d got sum %h cout %b err %b lat %0d want %h %b 0 4",
                                 i, av, s ? "-" : "+", bv, c, sm, co, er, lat, es, eco); end
    end
  endtask

  task automatic test_err();
    logic [15:0] sm; bit co, er; int lat, bc;
    run4(16'h00A5, 16'h0123, 1'b0, 1'b0, sm, co, er, lat, bc);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_a_flag got %b want 1", er); end
    checks++; if (sm !== 16'h0) begin errors++; $display("FAIL err_a_sum got %h want 0000", sm); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL err_a_cout got %b want 0", co); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL err_a_latency got %0d want 4", lat); end
    run4(16'h0000, 16'h9F00, 1'b1, 1'b1, sm, co, er, lat, bc);
    checks++; if (er !== 1'b1 || sm !== 16'h0 || co !== 1'b0)
      begin errors++; $display("FAIL err_b got err %b sum %h cout %b want 1 0000 0", er, sm, co); end
    run4(16'h0042, 16'h0017, 1'b0, 1'b0, sm, co, er, lat, bc);
    checks++; if (er !== 1'b0 || sm !== 16'h0059 || co !== 1'b0)
      begin errors++; $display("FAIL err_clear got err %b sum %h cout %b want 0 0059 0", er, sm, co); end
  endtask

  task automatic test_start_held();
    int q[$];
    int cyc = 0;
    bit sum_ok = 1'b1;
    @(negedge clk);
    if4.a = 16'h1234; if4.b = 16'h4321; if4.sub = 0; if4.cin = 0; if4.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (if4.done === 1'b1) begin
        q.push_back(cyc);
        if (if4.sum !== 16'h5555) sum_ok = 1'b0;
      end
    end
    if4.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (q.size() < 5) begin errors++; $display("FAIL held_count got %0d want >=5", q.size()); end
    for (int i = 1; i < q.size(); i++) begin
      checks++; if (q[i] - q[i-1] !== 6) begin errors++; $display("FAIL held_period%0d got %0d want 6", i, q[i] - q[i-1]); end
    end
    checks++; if (!sum_ok) begin errors++; $display("FAIL held_sum got mismatching sum want 5555"); end
  endtask

  task automatic test_ignore();
    logic [15:0] sm, got; bit co, er; int lat, bc;
    int ndone = 0;
    bit stable = 1'b1;
    got = '0;
    run4(16'h0042, 16'h0001, 1'b0, 1'b0, sm, co, er, lat, bc);
    @(negedge clk);
    if4.a = 16'h1111; if4.b = 16'h2222; if4.sub = 0; if4.cin = 0; if4.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if4.start = (i <= 4);
      if4.a = to_bcd(int'($urandom_range(0, 9999)), 4);
      if4.b = to_bcd(int'($urandom_range(0, 9999)), 4);
      if4.sub = 1'($urandom);
      @(posedge clk); #1;
      if (if4.done === 1'b1) begin ndone++; got = if4.sum; end
      else if (ndone == 0 && if4.sum !== 16'h0043) stable = 1'b0;
    end
    if4.start = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_dones got %0d want 1", ndone); end
    checks++; if (got !== 16'h3333) begin errors++; $display("FAIL ignore_sum got %h want 3333", got); end
    checks++; if (!stable) begin errors++; $display("FAIL ignore_stable got changing sum want 0043 held"); end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] sm; bit co, er; int lat, bc;
    run4(16'h9000, 16'h2000, 1'b0, 1'b1, sm, co, er, lat, bc);
    checks++; if (sm !== 16'h1001 || co !== 1'b1)
      begin errors++; $display("FAIL pre_rst got sum %h cout %b want 1001 1", sm, co); end
    @(negedge clk);
    if4.a = 16'h0777; if4.b = 16'h0111; if4.sub = 0; if4.cin = 0; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (if4.busy !== 1'b0 || if4.done !== 1'b0)
      begin errors++; $display("FAIL midrst_ctl got busy %b done %b want 0 0", if4.busy, if4.done); end
    checks++; if (if4.sum !== 16'h0 || if4.cout !== 1'b0 || if4.err !== 1'b0)
      begin errors++; $display("FAIL midrst_out got sum %h cout %b err %b want 0000 0 0", if4.sum, if4.cout, if4.err); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (if4.done !== 1'b0 || if4.sum !== 16'h0)
      begin errors++; $display("FAIL midrst_abort got done %b sum %h want 0 0000", if4.done, if4.sum); end
    run4(16'h0777, 16'h0111, 1'b0, 1'b0, sm, co, er, lat, bc);
    checks++; if (sm !== 16'h0888 || co !== 1'b0 || lat !== 4)
      begin errors++; $display("FAIL post_rst got sum %h cout %b lat %0d want 0888 0 4", sm, co, lat); end
  endtask

  task automatic test_digits1();
    int av, bv, sv, lat; bit s, c, eco;
    logic [15:0] tmp;
    logic [3:0] es;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin av = 7; bv = 5; s = 0; c = 0; end
      else begin
        av = int'($urandom_range(0, 9)); bv = int'($urandom_range(0, 9));
        s = 1'($urandom); c = 1'($urandom);
      end
      model(av, bv, s, c, 1, sv, eco);
      tmp = to_bcd(sv, 1);
      es = tmp[3:0];
      @(negedge clk);
      tmp = to_bcd(av, 1); if1.a = tmp[3:0];
      tmp = to_bcd(bv, 1); if1.b = tmp[3:0];
      if1.sub = s; if1.cin = c; if1.start = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      lat = 0;
      while (if1.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 1 || if1.sum !== es || if1.cout !== eco || if1.err !== 1'b0)
        begin errors++; $display("FAIL d1_op%0d %0d %s %0d cin%0d got sum %h cout %b err %b lat %0d want %h %b 0 1",
                                 i, av, s ? "-" : "+", bv, c, if1.sum, if1.cout, if1.err, lat, es, eco); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_err();
    test_start_held();
    test_ignore();
    test_reset_midrun();
    test_digits1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
